// File: rtl/dcache_types_pkg.sv
// Shared types and mux-select encodings for the 2-way data cache controller.
package dcache_types_pkg;
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_TAG_CHECK = 2'd1,
    S_WRITEBACK = 2'd2,
    S_FILL      = 2'd3
  } state_t;

  localparam logic ADDR_CPU    = 1'b0;
  localparam logic ADDR_VICTIM = 1'b1;
  localparam logic DIN_CPU     = 1'b0;
  localparam logic DIN_PMEM    = 1'b1;
endpackage

// File: rtl/dcache_perf_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module dcache_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_count <= '0;
    else if (i_inc && (r_count != '1))  r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/dcache_control.sv
// Control FSM for the 2-way set-associative data cache: hit service,
// dirty-victim writeback and line fill, plus hit/miss/writeback counters.
module dcache_control
  import dcache_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_read,
  input  logic             cpu_write,
  output logic             cpu_resp,
  input  logic             hit_way0,
  input  logic             hit_way1,
  input  logic             lru_way,
  input  logic             victim_valid,
  input  logic             victim_dirty,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic             addr_sel,
  output logic             data_in_sel,
  output logic [1:0]       data_we,
  output logic [1:0]       tag_load,
  output logic [1:0]       valid_load,
  output logic [1:0]       dirty_load,
  output logic             dirty_in,
  output logic             lru_load,
  output logic             lru_in,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);
  state_t r_state, w_next;
  logic   r_refill;
  logic   w_hit, w_hit_way;
  logic   w_hit_inc, w_miss_inc, w_wb_inc;

  assign w_hit     = hit_way0 | hit_way1;
  assign w_hit_way = ~hit_way0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Refill flag marks the retry after a fill so it is not counted as a first-try hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    r_refill <= 1'b0;
    else if (r_state == S_TAG_CHECK && w_hit)    r_refill <= 1'b0;
    else if (r_state == S_FILL && pmem_resp)     r_refill <= 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (cpu_read || cpu_write) w_next = S_TAG_CHECK;
      S_TAG_CHECK: begin
        if (w_hit)                              w_next = S_IDLE;
        else if (victim_valid && victim_dirty)  w_next = S_WRITEBACK;
        else                                    w_next = S_FILL;
      end
      S_WRITEBACK: if (pmem_resp) w_next = S_FILL;
      S_FILL:      if (pmem_resp) w_next = S_TAG_CHECK;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    addr_sel    = ADDR_CPU;
    data_in_sel = DIN_CPU;
    data_we     = 2'b00;
    tag_load    = 2'b00;
    valid_load  = 2'b00;
    dirty_load  = 2'b00;
    dirty_in    = 1'b0;
    lru_load    = 1'b0;
    lru_in      = 1'b0;
    case (r_state)
      S_TAG_CHECK: if (w_hit) begin
        cpu_resp = 1'b1;
        lru_load = 1'b1;
        lru_in   = ~w_hit_way;
        // cpu_write wins over a simultaneous cpu_read
        if (cpu_write) begin
          data_we[w_hit_way]    = 1'b1;
          data_in_sel           = DIN_CPU;
          dirty_load[w_hit_way] = 1'b1;
          dirty_in              = 1'b1;
        end
      end
      S_WRITEBACK: begin
        pmem_write = 1'b1;
        addr_sel   = ADDR_VICTIM;
      end
      S_FILL: begin
        pmem_read = 1'b1;
        addr_sel  = ADDR_CPU;
        if (pmem_resp) begin
          data_we[lru_way]    = 1'b1;
          data_in_sel         = DIN_PMEM;
          tag_load[lru_way]   = 1'b1;
          valid_load[lru_way] = 1'b1;
          dirty_load[lru_way] = 1'b1;
          dirty_in            = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign w_hit_inc  = (r_state == S_TAG_CHECK) && w_hit && !r_refill;
  assign w_miss_inc = (r_state == S_TAG_CHECK) && !w_hit;
  assign w_wb_inc   = (r_state == S_WRITEBACK) && pmem_resp;

  dcache_perf_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk(clk), .rst_n(rst), .i_inc(w_hit_inc), .o_count(hit_count)
  );
  dcache_perf_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk(clk), .rst_n(rst), .i_inc(w_miss_inc), .o_count(miss_count)
  );
  dcache_perf_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk(clk), .rst_n(rst), .i_inc(w_wb_inc), .o_count(wb_count)
  );
endmodule

// File: tb/tb_dcache_control.sv
// Bench for dcache_control: transaction-level model checked every cycle,
// plus hand-computed literal checks per directed scenario.
module tb_dcache_control;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst = 1'b0;
  logic cpu_read = 0, cpu_write = 0, hit_way0 = 0, hit_way1 = 0;
  logic lru_way = 0, victim_valid = 0, victim_dirty = 0, pmem_resp = 0;
  logic cpu_resp, pmem_read, pmem_write, addr_sel, data_in_sel, dirty_in, lru_load, lru_in;
  logic [1:0] data_we, tag_load, valid_load, dirty_load;
  logic [CW-1:0] hit_count, miss_count, wb_count;

  dcache_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_resp(cpu_resp),
    .hit_way0(hit_way0), .hit_way1(hit_way1), .lru_way(lru_way),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .addr_sel(addr_sel), .data_in_sel(data_in_sel), .data_we(data_we), .tag_load(tag_load),
    .valid_load(valid_load), .dirty_load(dirty_load), .dirty_in(dirty_in),
    .lru_load(lru_load), .lru_in(lru_in),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: what the cache controller is busy with.
  typedef enum int {M_WAIT_REQ, M_LOOKUP, M_EVICT, M_REFILL} mact_t;
  mact_t m_act;
  bit m_retry;
  int m_hits, m_miss, m_wbs;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act <= M_WAIT_REQ; m_retry <= 0; m_hits <= 0; m_miss <= 0; m_wbs <= 0;
    end else begin
      case (m_act)
        M_WAIT_REQ: if (cpu_read || cpu_write) m_act <= M_LOOKUP;
        M_LOOKUP:
          if (hit_way0 || hit_way1) begin
            if (!m_retry && m_hits < CMAX) m_hits <= m_hits + 1;
            m_retry <= 0;
            m_act <= M_WAIT_REQ;
          end else begin
            if (m_miss < CMAX) m_miss <= m_miss + 1;
            m_act <= (victim_valid && victim_dirty) ? M_EVICT : M_REFILL;
          end
        M_EVICT: if (pmem_resp) begin
          if (m_wbs < CMAX) m_wbs <= m_wbs + 1;
          m_act <= M_REFILL;
        end
        M_REFILL: if (pmem_resp) begin m_retry <= 1; m_act <= M_LOOKUP; end
        default: m_act <= M_WAIT_REQ;
      endcase
    end
  end

  // Expected output bundle:
  // {resp,prd,pwr,asel,dsel,we[2],tag[2],val[2],dl[2],din,lruld,lruin}
  function automatic logic [15:0] expect_outs();
    logic r = 0, prd = 0, pwr = 0, as = 0, ds = 0, din = 0, ll = 0, li = 0;
    logic [1:0] we = 0, tl = 0, vl = 0, dl = 0;
    int h;
    if (rst) begin
      if (m_act == M_LOOKUP && (hit_way0 || hit_way1)) begin
        h = hit_way0 ? 0 : 1;
        r = 1; ll = 1; li = (h == 0);
        if (cpu_write) begin we[h] = 1; dl[h] = 1; din = 1; end
      end else if (m_act == M_EVICT) begin
        pwr = 1; as = 1;
      end else if (m_act == M_REFILL) begin
        prd = 1;
        if (pmem_resp) begin
          we[lru_way] = 1; tl[lru_way] = 1; vl[lru_way] = 1; dl[lru_way] = 1; ds = 1;
        end
      end
    end
    return {r, prd, pwr, as, ds, we, tl, vl, dl, din, ll, li};
  endfunction

  // Monitor/snapshots for literal checks
  int cyc = 0, req_cyc = 0, resp_cyc = -1, resp_n = 0, prd_n = 0, pwr_as_n = 0;
  logic [1:0] s_we, s_dl, f_we, f_tl, f_vl;
  logic s_din, s_dsel, s_lruin, s_lruld, f_din, f_dsel;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("outputs", {cpu_resp, pmem_read, pmem_write, addr_sel, data_in_sel, data_we, tag_load,
                    valid_load, dirty_load, dirty_in, lru_load, lru_in}, expect_outs());
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_miss);
    chk("wb_count", wb_count, m_wbs);
    if (cpu_resp) begin
      resp_n++; resp_cyc = cyc;
      s_we = data_we; s_dl = dirty_load; s_din = dirty_in; s_dsel = data_in_sel;
      s_lruin = lru_in; s_lruld = lru_load;
    end
    if (pmem_read) prd_n++;
    if (pmem_write && addr_sel) pwr_as_n++;
    if (pmem_read && pmem_resp) begin
      f_we = data_we; f_tl = tag_load; f_vl = valid_load; f_din = dirty_in; f_dsel = data_in_sel;
    end
  end

  task automatic do_reset();
    rst = 0; cpu_read = 0; cpu_write = 0; hit_way0 = 0; hit_way1 = 0; pmem_resp = 0;
    victim_valid = 0; victim_dirty = 0; lru_way = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    resp_n = 0; resp_cyc = -1; prd_n = 0; pwr_as_n = 0;
  endtask

  task automatic pmem_pulse(input int lat);
    repeat (lat - 1) @(posedge clk);
    #1 pmem_resp = 1;
    @(posedge clk);
    #1 pmem_resp = 0;
  endtask

  // One CPU request; called 1 time unit after a rising edge.
  task automatic do_req(input bit rd, input bit wr, input bit h0, input bit h1,
                        input bit lw, input bit vv, input bit vd, input int wb_lat, input int fl_lat);
    cpu_read = rd; cpu_write = wr; hit_way0 = h0; hit_way1 = h1;
    lru_way = lw; victim_valid = vv; victim_dirty = vd;
    req_cyc = cyc;
    @(posedge clk); #1;
    if (!(h0 || h1)) begin
      @(posedge clk); #1;
      if (vv && vd) pmem_pulse(wb_lat);
      pmem_pulse(fl_lat);
      hit_way0 = (lw == 0); hit_way1 = (lw == 1);
    end
    @(posedge clk); #1;
    cpu_read = 0; cpu_write = 0; hit_way0 = 0; hit_way1 = 0;
  endtask

  initial begin
    #2;
    chk("rst_resp", cpu_resp, 0);
    chk("rst_hitcnt", hit_count, 0);
    do_reset();

    // Read hit way1
    do_req(1, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("rdhit_lat", resp_cyc - req_cyc, 1);
    chk("rdhit_lru", {s_lruld, s_lruin}, 2'b10);
    chk("rdhit_nopmem", prd_n + pwr_as_n, 0);
    chk("rdhit_cnt", hit_count, 1);

    // Write hit way0
    do_reset();
    do_req(0, 1, 1, 0, 1, 1, 1, 0, 0);
    chk("wrhit_we", s_we, 2'b01);
    chk("wrhit_dl", s_dl, 2'b01);
    chk("wrhit_din_sel_lru", {s_din, s_dsel, s_lruin}, 3'b101);

    // Both requests and both hits: write into way 0
    do_reset();
    do_req(1, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("bothhit_we", s_we, 2'b01);

    // Clean read miss, victim way 1, fill latency 5
    do_reset();
    do_req(1, 0, 0, 0, 1, 0, 1, 0, 5);
    chk("clean_prd_cycles", prd_n, 5);
    chk("clean_fill_we", f_we, 2'b10);
    chk("clean_fill_tag", f_tl, 2'b10);
    chk("clean_fill_val", f_vl, 2'b10);
    chk("clean_fill_din_sel", {f_din, f_dsel}, 2'b01);
    chk("clean_lat", resp_cyc - req_cyc, 7);
    chk("clean_counts", {miss_count, hit_count}, {4'd1, 4'd0});

    // Dirty write miss, victim way 0, writeback 3, fill 2
    do_reset();
    do_req(0, 1, 0, 0, 0, 1, 1, 3, 2);
    chk("dirty_wb_cycles", pwr_as_n, 3);
    chk("dirty_wbcnt", wb_count, 1);
    chk("dirty_fill_we", f_we, 2'b01);
    chk("dirty_retry_dl", {s_dl, s_din}, 3'b011);
    chk("dirty_lat", resp_cyc - req_cyc, 7);
    chk("dirty_counts", {miss_count, hit_count}, {4'd1, 4'd0});

    // Reset during fill, then stray pmem_resp
    do_reset();
    do_req(1, 0, 1, 0, 0, 0, 0, 0, 0);
    cpu_read = 1; lru_way = 1;
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    chk("pre_rst_prd", pmem_read, 1);
    rst = 0; #1;
    chk("rst_prd", pmem_read, 0);
    chk("rst_cnts", {hit_count, miss_count, wb_count}, 12'h000);
    cpu_read = 0;
    @(posedge clk); #1 rst = 1;
    pmem_resp = 1; @(posedge clk); #1 pmem_resp = 0;
    @(posedge clk); #1;
    chk("post_rst_idle", {pmem_read, pmem_write, cpu_resp}, 3'b000);

    // Saturation
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      do_req(1, 0, 0, 1, 0, 0, 0, 0, 0);
      if (i == 14) chk("sat_14", hit_count, 4'hE);
      if (i == 16) chk("sat_16", hit_count, 4'hF);
      if (i == 17) chk("sat_17", hit_count, 4'hF);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcache_control.md
Name: dcache_control

Overview:
- Control FSM for the 2-way set-associative data cache.
- Sits directly upstream of the per-way valid/dirty/tag/LRU arrays and the data array; generates all their load/write strobes from hit/victim status returned by the datapath.
- Sequences hit service, dirty-victim writeback and line fill over a request/response physical-memory handshake.
- Keeps saturating hit/miss/writeback performance counters.

Parameters:
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- cpu_read  in  1  CPU read request; held with address until cpu_resp
- cpu_write  in  1  CPU write request; held with address/data until cpu_resp
- cpu_resp  out  1  one-cycle completion pulse
- hit_way0  in  1  tag match and valid, way 0 (combinational from datapath)
- hit_way1  in  1  tag match and valid, way 1
- lru_way  in  1  victim way from LRU array read
- victim_valid  in  1  valid bit of way lru_way
- victim_dirty  in  1  dirty bit of way lru_way
- pmem_read  out  1  line read request to memory
- pmem_write  out  1  line write request to memory
- pmem_resp  in  1  memory completion pulse
- addr_sel  out  1  0: CPU address to pmem; 1: victim tag/index address
- data_in_sel  out  1  0: CPU write-merge data; 1: pmem line
- data_we  out  2  data array write enable per way
- tag_load  out  2  tag array load per way
- valid_load  out  2  valid array load per way (datain fixed 1)
- dirty_load  out  2  dirty array load per way
- dirty_in  out  1  dirty array datain
- lru_load  out  1  LRU array load
- lru_in  out  1  new LRU victim way
- hit_count  out  CNT_W  completed first-try hits
- miss_count  out  CNT_W  tag-check misses
- wb_count  out  CNT_W  completed writebacks

Behaviour:
- States: IDLE, TAG_CHECK, WRITEBACK, FILL. Reset state is IDLE.
- Async reset drives state to IDLE, clears the refill flag and all counters, and forces every output to 0 immediately, including during WRITEBACK/FILL.
- All strobes are combinational from state and inputs. Every output is 0 in any state/condition not listed below.
- IDLE:
  - cpu_read|cpu_write -> TAG_CHECK next cycle.
  - cpu_read and cpu_write together are treated as a write.
- TAG_CHECK, hit (hit_way0|hit_way1; hit way h = hit_way0 ? 0 : 1, way 0 has priority if both are asserted):
  - cpu_resp=1, lru_load=1, lru_in=~h.
  - If write: data_we[h]=1, data_in_sel=0, dirty_load[h]=1, dirty_in=1.
  - hit_count increments only when the refill flag is 0.
  - Clear refill flag; -> IDLE.
- TAG_CHECK, miss:
  - miss_count increments.
  - victim_valid&victim_dirty -> WRITEBACK, else -> FILL.
- WRITEBACK:
  - pmem_write=1, addr_sel=1, held until pmem_resp.
  - On pmem_resp: wb_count increments; -> FILL.
- FILL:
  - pmem_read=1, addr_sel=0, held until pmem_resp.
  - On pmem_resp (v=lru_way): data_we[v]=1, data_in_sel=1, tag_load[v]=1, valid_load[v]=1, dirty_load[v]=1, dirty_in=0.
  - Set refill flag; -> TAG_CHECK. The retry hits and services any write-merge.
- Latency:
  - Hit: request first seen in IDLE at cycle N; cpu_resp at N+1.
  - Clean miss: cpu_resp one cycle after the fill pmem_resp.
  - Dirty miss adds the writeback handshake.
- pmem_resp outside WRITEBACK/FILL is ignored.
- Request deassertion mid-operation is a protocol violation; the FSM completes the sequence regardless.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Package dcache_types_pkg: state enum, addr_sel constants (ADDR_CPU, ADDR_VICTIM), data_in_sel constants (DIN_CPU, DIN_PMEM).
- Sub-module dcache_perf_counter: parameterised CNT_W saturating counter with async active-low clear; instantiated three times.

Test Plan:
- Read hit way1: cpu_read=1, hit_way1=1 -> cpu_resp at cycle 2, lru_load=1, lru_in=0, no pmem activity, hit_count=1.
- Write hit way0 -> data_we=2'b01, data_in_sel=0, dirty_load=2'b01, dirty_in=1, lru_in=1 in the same cycle as cpu_resp.
- Clean read miss (victim_valid=0, lru_way=1), pmem_resp after 5 cycles:
  - pmem_read held 5 cycles.
  - Fill strobes data_we=2'b10, tag_load=2'b10, valid_load=2'b10, dirty_in=0.
  - Then TAG_CHECK with hit_way1 -> cpu_resp.
  - miss_count=1, hit_count=0.
- Dirty write miss:
  - pmem_write with addr_sel=1 until pmem_resp, wb_count=1.
  - Then FILL.
  - Then retry hit with dirty_in=1 on the victim way.
- Reset during FILL: rst=0 mid-handshake -> pmem_read drops to 0 immediately, all counters 0, state IDLE; later pmem_resp is ignored.
- Saturation: preload hit_count to all-ones via 2^CNT_W hits with CNT_W=4 -> after 16 and 17 hits, hit_count=4'hF.
